// File: rtl/dvp_pkg.sv
// Shared DVP definitions: FSM encodings, RGB565 bar colours, byte packing.
package dvp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_LINE   = 3'd3,
        ST_HBLANK = 3'd4,
        ST_VFRONT = 3'd5
    } dvp_state_e;

    // Bytes on the DVP bus per RGB565 pixel, high byte first
    localparam int unsigned BYTES_PER_PIXEL = 2;

    localparam int unsigned NUM_BARS = 8;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    // Colour of bar idx, left to right
    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = RGB_WHITE;
            3'd1:    c = RGB_YELLOW;
            3'd2:    c = RGB_CYAN;
            3'd3:    c = RGB_GREEN;
            3'd4:    c = RGB_MAGENTA;
            3'd5:    c = RGB_RED;
            3'd6:    c = RGB_BLUE;
            default: c = RGB_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dvp_bar_pattern.sv
// 8-bar colour generator; colour_c is the colour of the pixel being launched now.
module dvp_bar_pattern #(
    parameter int unsigned H_ACTIVE = 480
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        line_start,
    input  logic        pixel_advance,
    output logic [15:0] color_c
);
    import dvp_pkg::*;

    localparam int unsigned BAR_W = H_ACTIVE / NUM_BARS;
    localparam int unsigned CW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    logic [CW-1:0] cnt_q, cnt_d, base_cnt;
    logic [2:0]    idx_q, idx_d, base_idx;

    // line_start rewinds to bar 0 in the same cycle it launches the first pixel
    always_comb begin
        base_idx = line_start ? 3'd0 : idx_q;
        base_cnt = line_start ? '0 : cnt_q;
        idx_d    = base_idx;
        cnt_d    = base_cnt;
        if (pixel_advance) begin
            if (base_cnt == CW'(BAR_W - 1)) begin
                cnt_d = '0;
                if (base_idx != 3'd7) begin
                    idx_d = base_idx + 3'd1;
                end
            end else begin
                cnt_d = base_cnt + CW'(1);
            end
        end
        color_c = bar_color(base_idx);
    end

    // Bar position registers
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/dvp_source.sv
// DVP transmitter: frames RGB565 pixels (stream or colour bars) onto vsync/href/data.
module dvp_source #(
    parameter int unsigned H_ACTIVE = 480,
    parameter int unsigned V_ACTIVE = 272,
    parameter int unsigned H_BLANK  = 64,
    parameter int unsigned VS_LEN   = 8,
    parameter int unsigned V_BACK   = 16,
    parameter int unsigned V_FRONT  = 16
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        test_en,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    output logic        pix_ready,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  data,
    output logic        frame_done,
    output logic        underrun
);
    import dvp_pkg::*;

    localparam int unsigned CNT_W     = 12;
    localparam int unsigned MAX_A     = (VS_LEN > V_BACK) ? VS_LEN : V_BACK;
    localparam int unsigned MAX_B     = (H_BLANK > V_FRONT) ? H_BLANK : V_FRONT;
    localparam int unsigned BLANK_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned BW        = $clog2(BLANK_MAX + 1);
    localparam int unsigned PH_W      = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;

    dvp_state_e         state_q, state_d;
    logic [BW-1:0]      blank_q, blank_d;
    logic [CNT_W-1:0]   pix_q, pix_d;
    logic [CNT_W-1:0]   line_q, line_d;
    logic [PH_W-1:0]    ph_q, ph_d;
    logic               mode_q, mode_d;
    logic [7:0]         lo_q, lo_d;
    logic [7:0]         data_q, data_d;
    logic               vsync_q, vsync_d;
    logic               href_q, href_d;
    logic               frame_done_q, frame_done_d;
    logic               underrun_q, underrun_d;

    logic               last_vback_c, last_hblank_c, more_lines_c;
    logic               last_ph_c, last_pix_c, line_start_c, slot_c;
    logic               vs_entry_c;
    logic [15:0]        bar_color_c, src_c;

    // Decode of registered state: where the next high byte is launched from
    always_comb begin
        last_vback_c  = (state_q == ST_VBACK)  && (blank_q == BW'(V_BACK - 1));
        last_hblank_c = (state_q == ST_HBLANK) && (blank_q == BW'(H_BLANK - 1));
        more_lines_c  = (line_q != CNT_W'(V_ACTIVE - 1));
        last_ph_c     = (ph_q == PH_W'(BYTES_PER_PIXEL - 1));
        last_pix_c    = (pix_q == CNT_W'(H_ACTIVE - 1));
        line_start_c  = last_vback_c || (last_hblank_c && more_lines_c);
        slot_c        = line_start_c || ((state_q == ST_LINE) && last_ph_c && !last_pix_c);
        pix_ready     = slot_c && !mode_q;
    end

    dvp_bar_pattern #(
        .H_ACTIVE (H_ACTIVE)
    ) u_bars (
        .pclk          (pclk),
        .rst_n         (rst_n),
        .line_start    (line_start_c),
        .pixel_advance (slot_c && mode_q),
        .color_c       (bar_color_c)
    );

    // Next-state and counter sequencing
    always_comb begin
        state_d = state_q;
        blank_d = blank_q;
        pix_d   = pix_q;
        line_d  = line_q;
        ph_d    = ph_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_VSYNC;
                    blank_d = '0;
                end
            end
            ST_VSYNC: begin
                if (blank_q == BW'(VS_LEN - 1)) begin
                    state_d = ST_VBACK;
                    blank_d = '0;
                end else begin
                    blank_d = blank_q + BW'(1);
                end
            end
            ST_VBACK: begin
                if (last_vback_c) begin
                    state_d = ST_LINE;
                    line_d  = '0;
                    pix_d   = '0;
                    ph_d    = '0;
                end else begin
                    blank_d = blank_q + BW'(1);
                end
            end
            ST_LINE: begin
                if (last_ph_c) begin
                    if (last_pix_c) begin
                        state_d = ST_HBLANK;
                        blank_d = '0;
                    end else begin
                        pix_d = pix_q + CNT_W'(1);
                        ph_d  = '0;
                    end
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            ST_HBLANK: begin
                if (last_hblank_c) begin
                    if (more_lines_c) begin
                        state_d = ST_LINE;
                        line_d  = line_q + CNT_W'(1);
                        pix_d   = '0;
                        ph_d    = '0;
                    end else begin
                        state_d = ST_VFRONT;
                        blank_d = '0;
                    end
                end else begin
                    blank_d = blank_q + BW'(1);
                end
            end
            ST_VFRONT: begin
                blank_d = '0;
                if (blank_q == BW'(V_FRONT - 1)) begin
                    state_d = enable ? ST_VSYNC : ST_IDLE;
                end else begin
                    blank_d = blank_q + BW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                blank_d = '0;
            end
        endcase
    end

    // Outputs computed one cycle ahead so the registered pins line up with state_q
    always_comb begin
        vs_entry_c   = (state_d == ST_VSYNC) && (state_q != ST_VSYNC);
        mode_d       = vs_entry_c ? test_en : mode_q;
        underrun_d   = vs_entry_c ? 1'b0 : (underrun_q || (pix_ready && !pix_valid));
        vsync_d      = (state_d == ST_VSYNC);
        href_d       = (state_d == ST_LINE);
        frame_done_d = (state_d == ST_VFRONT) && (blank_d == BW'(V_FRONT - 1));
        src_c        = mode_q ? bar_color_c : (pix_valid ? pix_data : 16'h0000);
        lo_d         = lo_q;
        data_d       = 8'h00;
        if (slot_c) begin
            data_d = src_c[15:8];
            lo_d   = src_c[7:0];
        end else if (state_d == ST_LINE) begin
            data_d = lo_q;
        end
    end

    // State, counters and output registers
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            blank_q      <= '0;
            pix_q        <= '0;
            line_q       <= '0;
            ph_q         <= '0;
            mode_q       <= 1'b0;
            lo_q         <= 8'h00;
            data_q       <= 8'h00;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            blank_q      <= blank_d;
            pix_q        <= pix_d;
            line_q       <= line_d;
            ph_q         <= ph_d;
            mode_q       <= mode_d;
            lo_q         <= lo_d;
            data_q       <= data_d;
            vsync_q      <= vsync_d;
            href_q       <= href_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
        end
    end

    assign vsync      = vsync_q;
    assign href       = href_q;
    assign data       = data_q;
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_dvp_source.sv
// Scoreboarded bench for dvp_source with a small frame geometry (47-cycle frames).
module tb_dvp_source;

    localparam int unsigned H_ACTIVE = 8;
    localparam int unsigned V_ACTIVE = 2;
    localparam int unsigned H_BLANK  = 4;
    localparam int unsigned VS_LEN   = 3;
    localparam int unsigned V_BACK   = 2;
    localparam int unsigned V_FRONT  = 2;

    logic        pclk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic        test_en = 1'b0;
    logic        pix_valid = 1'b0;
    logic [15:0] pix_data = 16'h0000;
    logic        pix_ready;
    logic        vsync;
    logic        href;
    logic [7:0]  data;
    logic        frame_done;
    logic        underrun;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    bit          mon_en = 1'b1;
    int          slot_k = 0;
    int          drop_k = -1;
    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    dvp_source #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .H_BLANK  (H_BLANK),
        .VS_LEN   (VS_LEN),
        .V_BACK   (V_BACK),
        .V_FRONT  (V_FRONT)
    ) dut (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .enable     (enable),
        .test_en    (test_en),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_ready  (pix_ready),
        .vsync      (vsync),
        .href       (href),
        .data       (data),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected bytes for a stream frame; pixel k is A5C3+k, or zero if dropped
    task automatic push_stream(input int drop);
        logic [15:0] p;
        for (int k = 0; k < 16; k++) begin
            p = (k == drop) ? 16'h0000 : 16'hA5C3 + 16'(k);
            exp_q.push_back(p[15:8]);
            exp_q.push_back(p[7:0]);
        end
    endtask

    task automatic push_bars();
        logic [15:0] p;
        for (int l = 0; l < 2; l++) begin
            for (int i = 0; i < 8; i++) begin
                p = bars[i];
                exp_q.push_back(p[15:8]);
                exp_q.push_back(p[7:0]);
            end
        end
    endtask

    // Upstream source: presents pixel slot_k, withholds valid for the dropped slot
    initial begin
        forever begin
            @(negedge pclk);
            pix_data  = 16'hA5C3 + 16'(slot_k);
            pix_valid = (slot_k != drop_k);
            if (pix_ready) slot_k++;
        end
    end

    // Monitor: every href byte is popped from the scoreboard and compared
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge pclk);
            if (mon_en && href) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL byte_unexpected: got %0h, expected no href byte", data);
                end else begin
                    e = exp_q.pop_front();
                    chk("href_byte", 32'(data), 32'(e));
                end
            end
        end
    end

    // Called at the negedge of the first VSYNC cycle; measures the whole frame
    task automatic run_frame(input logic exp_under, input int exp_slots,
                             input int toggle_at, input int stop_at);
        int   c, vs_len, runs, bad_len, cur_len, first_href, done_idx;
        logic prev;
        chk("vsync_start", 32'(vsync), 32'd1);
        chk("underrun_cleared", 32'(underrun), 32'd0);
        slot_k = 0;
        c = 1; vs_len = 0; runs = 0; bad_len = 0; cur_len = 0;
        first_href = 0; done_idx = 0; prev = 1'b0;
        while (done_idx == 0 && c <= 100) begin
            vs_len += int'(vsync);
            if (href) begin
                if (!prev) begin
                    runs++;
                    cur_len = 0;
                    if (first_href == 0) first_href = c;
                end
                cur_len++;
            end else if (prev && cur_len != 16) begin
                bad_len++;
            end
            prev = href;
            if (frame_done) done_idx = c;
            if (c == toggle_at) test_en = !test_en;
            if (c == stop_at) enable = 1'b0;
            if (done_idx == 0) begin
                @(negedge pclk);
                c++;
            end
        end
        chk("vsync_len", 32'(vs_len), 32'd3);
        chk("first_href_cycle", 32'(first_href), 32'd6);
        chk("href_runs", 32'(runs), 32'd2);
        chk("href_bad_runs", 32'(bad_len), 32'd0);
        chk("frame_done_cycle", 32'(done_idx), 32'd47);
        chk("underrun_at_end", 32'(underrun), 32'(exp_under));
        chk("accepts", 32'(slot_k), 32'(exp_slots));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_cnt, vs_cnt;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge pclk);
        chk("rst_vsync", 32'(vsync), 32'd0);
        chk("rst_href", 32'(href), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_pix_ready", 32'(pix_ready), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge pclk);
        chk("idle_vsync", 32'(vsync), 32'd0);
        chk("idle_href", 32'(href), 32'd0);

        // Frame A: clean stream
        push_stream(-1);
        enable = 1'b1;
        @(negedge pclk);
        run_frame(1'b0, 16, 0, 0);

        // Frame B: third pixel of line 0 missing
        drop_k = 2;
        push_stream(2);
        @(negedge pclk);
        run_frame(1'b1, 16, 0, 0);

        // Frame C: colour bars; test_en dropped mid-frame
        drop_k = -1;
        test_en = 1'b1;
        push_bars();
        @(negedge pclk);
        run_frame(1'b0, 0, 20, 0);

        // Frame D: stream; test_en raised mid-frame
        push_stream(-1);
        @(negedge pclk);
        run_frame(1'b0, 16, 20, 0);

        // Frame E: stream, enable dropped during line 1
        test_en = 1'b0;
        push_stream(-1);
        @(negedge pclk);
        run_frame(1'b0, 16, 0, 30);
        done_cnt = 0;
        vs_cnt = 0;
        repeat (10) begin
            @(negedge pclk);
            done_cnt += int'(frame_done);
            vs_cnt += int'(vsync);
        end
        chk("stop_no_vsync", 32'(vs_cnt), 32'd0);
        chk("stop_no_done", 32'(done_cnt), 32'd0);

        // Frame F: restart must show vsync on the very next cycle
        push_stream(-1);
        enable = 1'b1;
        @(negedge pclk);
        run_frame(1'b0, 16, 0, 0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        // Reset asserted mid-line
        mon_en = 1'b0;
        for (int i = 0; i < 40 && !href; i++) @(negedge pclk);
        chk("pre_reset_href", 32'(href), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_vsync", 32'(vsync), 32'd0);
        chk("midrst_href", 32'(href), 32'd0);
        chk("midrst_data", 32'(data), 32'd0);
        chk("midrst_pix_ready", 32'(pix_ready), 32'd0);
        chk("midrst_frame_done", 32'(frame_done), 32'd0);
        enable = 1'b0;
        exp_q.delete();
        @(negedge pclk);
        rst_n = 1'b1;
        repeat (5) @(negedge pclk);
        chk("post_rst_idle_vsync", 32'(vsync), 32'd0);
        chk("post_rst_idle_href", 32'(href), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dvp_source.md
Name: dvp_source

Overview:
- DVP transmitter that drives vsync, href and an 8-bit data bus on pclk, using the same timing our DVP capture block consumes.
- Serialises RGB565 pixels high byte first, from a valid/ready pixel stream or from an internal 8-bar colour pattern.
- Used as an OV5640 stand-in for simulation, loopback bring-up, and display-path testing without the sensor.

Parameters:
- H_ACTIVE, 480, pixels per line (>=8).
- V_ACTIVE, 272, lines per frame (>=1).
- H_BLANK, 64, pclk cycles href low between lines (>=1).
- VS_LEN, 8, pclk cycles vsync high per frame (>=1).
- V_BACK, 16, pclk cycles between vsync fall and first href rise (>=1).
- V_FRONT, 16, pclk cycles after last line's blanking before next vsync (>=1).

Ports:
- pclk  in  1  pixel clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run frames; sampled at frame boundaries.
- test_en  in  1  1 = colour bars, 0 = pixel stream; latched at frame start.
- pix_valid  in  1  upstream pixel valid.
- pix_data  in  16  upstream RGB565 pixel.
- pix_ready  out  1  pixel accepted this cycle.
- vsync  out  1  frame sync, active high.
- href  out  1  line valid, active high.
- data  out  8  DVP byte.
- frame_done  out  1  one-cycle pulse at end of frame.
- underrun  out  1  frame had at least one missing stream pixel.

Behaviour:
- Reset (async, any state): state=IDLE; vsync, href, pix_ready, frame_done, underrun = 0; data = 8'h00; all counters = 0.
- vsync, href, data and frame_done are registered. pix_ready is decoded from registered state only.
- States: IDLE, VSYNC, VBACK, LINE, HBLANK, VFRONT.
- IDLE: outputs low. When enable=1, go to VSYNC next cycle.
- On entry to VSYNC: latch test_en into mode_q and clear underrun.
- VSYNC: vsync=1 for exactly VS_LEN cycles, then VBACK.
- VBACK: V_BACK cycles, then LINE with line counter = 0.
- LINE: href=1 for exactly 2*H_ACTIVE cycles, then HBLANK.
- HBLANK: H_BLANK cycles. Then LINE if more lines remain; otherwise VFRONT.
- VFRONT: V_FRONT cycles. frame_done=1 on the last VFRONT cycle. Then VSYNC if enable=1, else IDLE.
- enable deassertion mid-frame: the frame completes normally.
- Byte order: each pixel occupies two consecutive href cycles, data=pixel[15:8] then pixel[7:0]. The low byte is held in a register.
- Stream mode (mode_q=0):
  - pix_ready=1 in the cycle immediately preceding each high-byte cycle: the last VBACK or HBLANK cycle, or the low-byte cycle of the previous pixel.
  - A pixel accepted in cycle n appears as the high byte in cycle n+1 and the low byte in cycle n+2.
  - pix_ready=1 with pix_valid=0: transmit 16'h0000 for that pixel and set underrun. underrun stays set until the next VSYNC entry.
  - pix_ready is never 1 outside these slots. Exactly H_ACTIVE accepts per line, V_ACTIVE*H_ACTIVE per frame.
- Pattern mode (mode_q=1):
  - pix_ready held 0; pix_valid is ignored.
  - Bar width BAR_W = H_ACTIVE/8 (integer division). Bar index advances every BAR_W pixels and saturates at 7.
  - Bar colours, index 0..7: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - Bar index resets to 0 at the start of every line.
- Counter widths: pixel and line counters 12 bits; blanking counter sized to the largest blanking parameter.
- test_en changes mid-frame have no effect until the next VSYNC entry.

Decomposition:
- Shared package/include dvp_pkg holds:
  - state encodings;
  - RGB565 bar colour constants;
  - a BYTES_PER_PIXEL=2 constant, shared with the capture side.
- Sub-module dvp_bar_pattern:
  - inputs: pclk, rst_n, line_start, pixel_advance;
  - output: 16-bit colour;
  - parameter: H_ACTIVE.

Test Plan:
Small-parameter bench: H_ACTIVE=8, V_ACTIVE=2, H_BLANK=4, VS_LEN=3, V_BACK=2, V_FRONT=2, so a frame is 3+2+2*(16+4)+2 = 47 cycles.
- Reset: assert rst_n=0 mid-line with href=1 -> vsync, href, data, pix_ready, frame_done all 0 within the same cycle. After release with enable=0, IDLE is held.
- Stream framing: enable=1, test_en=0, pix_valid=1, pix_data=16'hA5C3+k -> vsync high 3 cycles; href high 16 cycles twice, 4 low between; data sequence A5,C3,A5,C4,...; 16 accepts; frame_done at cycle 47; underrun=0.
- Underrun: drop pix_valid for the 3rd pixel of line 0 -> bytes 00,00 in href cycles 5-6 and underrun=1 through frame end. underrun clears on the next VSYNC entry.
- Colour bars: test_en=1 -> each line bytes FF,FF,FF,E0,07,FF,07,E0,F8,1F,F8,00,00,1F,00,00 and pix_ready never 1. Toggling test_en mid-frame has no effect until the next frame.
- Stop and restart: deassert enable during line 1 -> the frame finishes, frame_done pulses once, the block returns to IDLE. Re-enable -> VSYNC starts on the next cycle.
- Loopback: connect to the team's DVP capture block; stream 16 pixels 0..15 -> the capture block emits matching 16-bit pixels (after its initial frame drop) with xaddr 0..7 and yaddr 1..2.
